// File: rtl/eth_crc32_stream.sv
`default_nettype none
// ============================================================================
//  Module   : eth_crc32_stream
//  Purpose  : Streaming Ethernet CRC-32 (reflected, poly 0xEDB88320) that passes
//             payload beats through one output register and appends the FCS.
//             Optional receive-side check mode under macro CRC_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module eth_crc32_stream #(
  parameter int          DATA_W   = 8,
  parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [31:0]       crc_val,
`ifdef CRC_CHECK_EN
  input  logic              chk_mode,
  output logic              crc_ok,
  output logic              crc_err,
`endif
  output logic              crc_done
);

  localparam logic [31:0] c_POLY      = 32'hEDB88320;
  localparam logic [2:0]  c_LAST_BEAT = 3'(32 / DATA_W - 1);
`ifdef CRC_CHECK_EN
  localparam logic [31:0] c_RESIDUE   = 32'hDEBB20E3;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_FCS  = 2'd2
  } state_t;

  state_t              r_state;
  logic [31:0]         r_crc;
  logic [31:0]         r_fcs_sh;
  logic [2:0]          r_fcs_cnt;
  logic                r_m_valid;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_last;
  logic [31:0]         r_crc_val;
  logic                r_crc_done;
  logic [31:0]         w_crc_base;
  logic [31:0]         w_crc_next;
  logic                w_accept;
  logic                w_chk;
`ifdef CRC_CHECK_EN
  logic                r_chk;
  logic                r_crc_ok;
  logic                r_crc_err;
`endif

  // Fold DATA_W bits, bit 0 first, into the reflected CRC register.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DATA_W-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < DATA_W; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ c_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    w_crc_base = (r_state == S_IDLE) ? CRC_INIT : r_crc;
    w_crc_next = crc_step(w_crc_base, s_data);
  end

  assign s_ready  = rst_n & (r_state != S_FCS) & (~r_m_valid | m_ready);
  assign w_accept = s_valid & s_ready;

`ifdef CRC_CHECK_EN
  // Check mode is latched on a frame's first beat and held for the rest of it.
  assign w_chk = (r_state == S_IDLE) ? chk_mode : r_chk;
`else
  assign w_chk = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_crc      <= CRC_INIT;
      r_fcs_sh   <= 32'd0;
      r_fcs_cnt  <= 3'd0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
      r_crc_val  <= 32'd0;
      r_crc_done <= 1'b0;
`ifdef CRC_CHECK_EN
      r_chk      <= 1'b0;
      r_crc_ok   <= 1'b0;
      r_crc_err  <= 1'b0;
`endif
    end else begin
      r_crc_done <= 1'b0;
`ifdef CRC_CHECK_EN
      r_crc_ok   <= 1'b0;
      r_crc_err  <= 1'b0;
`endif
      if (frame_abort) begin
        r_state   <= S_IDLE;
        r_crc     <= CRC_INIT;
        r_fcs_cnt <= 3'd0;
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DATA: begin
            if (w_accept) begin
              r_m_valid <= 1'b1;
              r_m_data  <= s_data;
              r_m_last  <= w_chk & s_last;
              r_crc     <= w_crc_next;
`ifdef CRC_CHECK_EN
              r_chk     <= w_chk;
`endif
              if (s_last) begin
                r_crc_val  <= ~w_crc_next;
                r_crc_done <= 1'b1;
                if (w_chk) begin
                  r_state <= S_IDLE;
                  r_crc   <= CRC_INIT;
`ifdef CRC_CHECK_EN
                  r_crc_ok  <= (w_crc_next == c_RESIDUE);
                  r_crc_err <= (w_crc_next != c_RESIDUE);
`endif
                end else begin
                  r_state   <= S_FCS;
                  r_fcs_sh  <= ~w_crc_next;
                  r_fcs_cnt <= 3'd0;
                end
              end else begin
                r_state <= S_DATA;
              end
            end else if (m_ready) begin
              r_m_valid <= 1'b0;
            end
          end
          S_FCS: begin
            // Each handshake frees the output register for the next FCS beat.
            if (r_m_valid & m_ready) begin
              if (r_m_last) begin
                r_state   <= S_IDLE;
                r_crc     <= CRC_INIT;
                r_fcs_cnt <= 3'd0;
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
              end else begin
                r_m_data  <= r_fcs_sh[DATA_W-1:0];
                r_fcs_sh  <= r_fcs_sh >> DATA_W;
                r_m_last  <= (r_fcs_cnt == c_LAST_BEAT);
                r_fcs_cnt <= r_fcs_cnt + 3'd1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_last   = r_m_last;
  assign crc_val  = r_crc_val;
  assign crc_done = r_crc_done;
`ifdef CRC_CHECK_EN
  assign crc_ok   = r_crc_ok;
  assign crc_err  = r_crc_err;
`endif

endmodule
`default_nettype wire
